// File: rtl/light_seq_monitor.sv
// light_seq_monitor
// Safety observer for the traffic-light controller. It decodes the one-hot
// light drive back into a phase, checks the phase order and the per-phase
// dwell, and latches the first violation as a fault code. It also reports
// the number of completed cycles and the dwell of the phase just left.
module light_seq_monitor #(
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MIN_YELLOW = 4,
    parameter int unsigned MIN_RED    = 4,
    parameter int unsigned MAX_DWELL  = 200
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [2:0]       lights_i,
    input  logic             clr_fault_i,
    output logic [1:0]       phase_o,
    output logic             fault_o,
    output logic [2:0]       fault_code_o,
    output logic [7:0]       cycle_cnt_o,
    output logic [CNT_W-1:0] last_dwell_o
);

    // Prescaler width; at least one bit so TICK_DIV = 1 still elaborates.
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] LIGHT_OFF = 3'b000;
    localparam logic [2:0] LIGHT_G   = 3'b100;
    localparam logic [2:0] LIGHT_Y   = 3'b010;
    localparam logic [2:0] LIGHT_R   = 3'b001;

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_CODE  = 3'd1;
    localparam logic [2:0] FC_TRANS = 3'd2;
    localparam logic [2:0] FC_SHORT = 3'd3;
    localparam logic [2:0] FC_STUCK = 3'd4;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DWELL_SAT  = {CNT_W{1'b1}};
    // The dwell value whose next tick makes it reach MAX_DWELL.
    localparam logic [CNT_W-1:0] STUCK_AT   = CNT_W'(MAX_DWELL - 1);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_RED    = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    // True when exactly one of the three lamps is driven.
    function automatic logic is_one_hot(input logic [2:0] v);
        return (v == LIGHT_G) || (v == LIGHT_Y) || (v == LIGHT_R);
    endfunction

    // Phase number reported for a given state; FAULT reports no phase.
    function automatic logic [1:0] phase_of(input state_e s);
        logic [1:0] p;
        case (s)
            ST_GREEN:  p = 2'd1;
            ST_YELLOW: p = 2'd2;
            ST_RED:    p = 2'd3;
            default:   p = 2'd0;
        endcase
        return p;
    endfunction

    logic [2:0]       lights_q_r;
    logic [PW-1:0]    presc_r;
    logic             tick_s;
    state_e           state_r;
    state_e           next_state_s;
    state_e           succ_state_s;
    logic [2:0]       cur_code_s;
    logic [2:0]       succ_code_s;
    logic [CNT_W-1:0] min_dwell_s;
    logic [CNT_W-1:0] dwell_r;
    logic [CNT_W-1:0] next_dwell_s;
    logic [CNT_W-1:0] dwell_inc_s;
    logic [2:0]       fault_code_r;
    logic [2:0]       next_code_s;
    logic [7:0]       cycle_cnt_r;
    logic [7:0]       next_cycle_s;
    logic [CNT_W-1:0] last_dwell_r;
    logic [CNT_W-1:0] next_last_s;
    logic [1:0]       phase_r;
    logic             fault_r;

    assign tick_s      = (presc_r == PRESC_LAST);
    assign dwell_inc_s = (dwell_r == DWELL_SAT) ? dwell_r : (dwell_r + {{(CNT_W-1){1'b0}}, 1'b1});

    // Input capture stage and free-running dwell-tick prescaler.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lights_q_r <= LIGHT_OFF;
            presc_r    <= '0;
        end else begin
            lights_q_r <= lights_i;
            if (tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Per-phase lamp code, legal successor and minimum dwell of the current phase.
    always_comb begin
        cur_code_s   = LIGHT_OFF;
        succ_code_s  = LIGHT_OFF;
        succ_state_s = ST_FAULT;
        min_dwell_s  = '0;
        case (state_r)
            ST_GREEN: begin
                cur_code_s   = LIGHT_G;
                succ_code_s  = LIGHT_Y;
                succ_state_s = ST_YELLOW;
                min_dwell_s  = CNT_W'(MIN_GREEN);
            end
            ST_YELLOW: begin
                cur_code_s   = LIGHT_Y;
                succ_code_s  = LIGHT_R;
                succ_state_s = ST_RED;
                min_dwell_s  = CNT_W'(MIN_YELLOW);
            end
            ST_RED: begin
                cur_code_s   = LIGHT_R;
                succ_code_s  = LIGHT_G;
                succ_state_s = ST_GREEN;
                min_dwell_s  = CNT_W'(MIN_RED);
            end
            default: begin
                cur_code_s   = LIGHT_OFF;
                succ_code_s  = LIGHT_OFF;
                succ_state_s = ST_FAULT;
                min_dwell_s  = '0;
            end
        endcase
    end

    // Next-state, fault classification and dwell/cycle bookkeeping.
    always_comb begin
        next_state_s = state_r;
        next_code_s  = fault_code_r;
        next_dwell_s = dwell_r;
        next_last_s  = last_dwell_r;
        next_cycle_s = cycle_cnt_r;
        case (state_r)
            ST_INIT: begin
                // First entry into a phase: no dwell check and no cycle count.
                case (lights_q_r)
                    LIGHT_OFF: next_state_s = ST_INIT;
                    LIGHT_G: begin
                        next_state_s = ST_GREEN;
                        next_dwell_s = '0;
                    end
                    LIGHT_Y: begin
                        next_state_s = ST_YELLOW;
                        next_dwell_s = '0;
                    end
                    LIGHT_R: begin
                        next_state_s = ST_RED;
                        next_dwell_s = '0;
                    end
                    default: begin
                        next_state_s = ST_FAULT;
                        next_code_s  = FC_CODE;
                    end
                endcase
            end
            ST_GREEN, ST_YELLOW, ST_RED: begin
                if (!is_one_hot(lights_q_r)) begin
                    next_state_s = ST_FAULT;
                    next_code_s  = FC_CODE;
                end else if (lights_q_r == cur_code_s) begin
                    if (tick_s) begin
                        if (dwell_r >= STUCK_AT) begin
                            next_state_s = ST_FAULT;
                            next_code_s  = FC_STUCK;
                        end else begin
                            next_dwell_s = dwell_inc_s;
                        end
                    end else begin
                        next_dwell_s = dwell_r;
                    end
                end else if (lights_q_r != succ_code_s) begin
                    next_state_s = ST_FAULT;
                    next_code_s  = FC_TRANS;
                end else if (dwell_r < min_dwell_s) begin
                    next_state_s = ST_FAULT;
                    next_code_s  = FC_SHORT;
                end else begin
                    next_state_s = succ_state_s;
                    next_last_s  = dwell_r;
                    next_dwell_s = '0;
                    if (state_r == ST_RED) begin
                        next_cycle_s = cycle_cnt_r + 8'd1;
                    end else begin
                        next_cycle_s = cycle_cnt_r;
                    end
                end
            end
            ST_FAULT: begin
                // The lamps are ignored here; only an explicit clear leaves FAULT.
                if (clr_fault_i) begin
                    next_state_s = ST_INIT;
                    next_code_s  = FC_NONE;
                    next_dwell_s = '0;
                end else begin
                    next_state_s = ST_FAULT;
                end
            end
            default: begin
                next_state_s = ST_FAULT;
                next_code_s  = FC_CODE;
            end
        endcase
    end

    // State, dwell and report registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_INIT;
            dwell_r      <= '0;
            fault_code_r <= FC_NONE;
            cycle_cnt_r  <= 8'd0;
            last_dwell_r <= '0;
        end else begin
            state_r      <= next_state_s;
            dwell_r      <= next_dwell_s;
            fault_code_r <= next_code_s;
            cycle_cnt_r  <= next_cycle_s;
            last_dwell_r <= next_last_s;
        end
    end

    // Registered phase/fault flags, decoded from the next state so they track state_r.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_r <= 2'd0;
            fault_r <= 1'b0;
        end else begin
            phase_r <= phase_of(next_state_s);
            fault_r <= (next_state_s == ST_FAULT);
        end
    end

    assign phase_o      = phase_r;
    assign fault_o      = fault_r;
    assign fault_code_o = fault_code_r;
    assign cycle_cnt_o  = cycle_cnt_r;
    assign last_dwell_o = last_dwell_r;

endmodule

// File: tb/tb_light_seq_monitor.sv
// Directed bench for light_seq_monitor. dut_a runs with TICK_DIV = 1 and
// MAX_DWELL = 20, dut_b with TICK_DIV = 4 and MAX_DWELL = 20 (stuck test).
// Dwell arithmetic: a code held for n steps after entry is seen by the FSM
// on n-1 ticks after the entry edge, so a 6-step hold leaves dwell 5 and a
// 5-step hold leaves dwell 4 (exactly MIN).
module tb_light_seq_monitor;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;

    logic       clk;
    logic       rst_n;
    logic [2:0] lights;
    logic       clr;

    logic [1:0] a_phase;
    logic       a_fault;
    logic [2:0] a_code;
    logic [7:0] a_cycle;
    logic [7:0] a_last;
    logic [1:0] b_phase;
    logic       b_fault;
    logic [2:0] b_code;
    logic [7:0] b_cycle;
    logic [7:0] b_last;

    int check_cnt;
    int pass_cnt;

    light_seq_monitor #(
        .TICK_DIV(1), .CNT_W(8), .MIN_GREEN(4), .MIN_YELLOW(4), .MIN_RED(4), .MAX_DWELL(20)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .lights_i(lights), .clr_fault_i(clr),
        .phase_o(a_phase), .fault_o(a_fault), .fault_code_o(a_code),
        .cycle_cnt_o(a_cycle), .last_dwell_o(a_last)
    );

    light_seq_monitor #(
        .TICK_DIV(4), .CNT_W(8), .MIN_GREEN(4), .MIN_YELLOW(4), .MIN_RED(4), .MAX_DWELL(20)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .lights_i(lights), .clr_fault_i(clr),
        .phase_o(b_phase), .fault_o(b_fault), .fault_code_o(b_code),
        .cycle_cnt_o(b_cycle), .last_dwell_o(b_last)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [2:0] l);
        lights = l;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) step(l);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        lights = 3'b000;
        clr    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        lights = 3'b000;
        clr    = 1'b0;
        @(posedge clk);
        #1;
        check_cnt++; if (a_phase !== 2'd0) $display("FAIL reset_phase: got %0d want 0", a_phase); else pass_cnt++;
        check_cnt++; if (a_fault !== 1'b0) $display("FAIL reset_fault: got %0d want 0", a_fault); else pass_cnt++;
        check_cnt++; if (a_code !== 3'd0) $display("FAIL reset_code: got %0d want 0", a_code); else pass_cnt++;
        check_cnt++; if (a_cycle !== 8'd0) $display("FAIL reset_cycle: got %0d want 0", a_cycle); else pass_cnt++;
        check_cnt++; if (a_last !== 8'd0) $display("FAIL reset_last: got %0d want 0", a_last); else pass_cnt++;
        rst_n = 1'b1;
        hold(3'b000, 3);
        check_cnt++; if (a_phase !== 2'd0 || a_fault !== 1'b0) $display("FAIL init_idle: got phase %0d fault %0d want 0 0", a_phase, a_fault); else pass_cnt++;
    endtask

    task automatic test_legal_sequence();
        step(G);
        check_cnt++; if (a_phase !== 2'd0) $display("FAIL seq_latency: got %0d want 0", a_phase); else pass_cnt++;
        step(G);
        check_cnt++; if (a_phase !== 2'd1) $display("FAIL seq_green: got %0d want 1", a_phase); else pass_cnt++;
        hold(G, 4);
        step(Y);
        check_cnt++; if (a_phase !== 2'd1) $display("FAIL seq_y_latency: got %0d want 1", a_phase); else pass_cnt++;
        step(Y);
        check_cnt++; if (a_phase !== 2'd2) $display("FAIL seq_yellow: got %0d want 2", a_phase); else pass_cnt++;
        check_cnt++; if (a_last !== 8'd5) $display("FAIL seq_last_g: got %0d want 5", a_last); else pass_cnt++;
        hold(Y, 4);
        hold(R, 2);
        check_cnt++; if (a_phase !== 2'd3) $display("FAIL seq_red: got %0d want 3", a_phase); else pass_cnt++;
        check_cnt++; if (a_last !== 8'd5) $display("FAIL seq_last_y: got %0d want 5", a_last); else pass_cnt++;
        check_cnt++; if (a_cycle !== 8'd0) $display("FAIL seq_cycle0: got %0d want 0", a_cycle); else pass_cnt++;
        hold(R, 4);
        hold(G, 2);
        check_cnt++; if (a_phase !== 2'd1) $display("FAIL seq_green2: got %0d want 1", a_phase); else pass_cnt++;
        check_cnt++; if (a_cycle !== 8'd1) $display("FAIL seq_cycle1: got %0d want 1", a_cycle); else pass_cnt++;
        check_cnt++; if (a_last !== 8'd5) $display("FAIL seq_last_r: got %0d want 5", a_last); else pass_cnt++;
        check_cnt++; if (a_fault !== 1'b0) $display("FAIL seq_nofault: got %0d want 0", a_fault); else pass_cnt++;
    endtask

    task automatic test_short_dwell();
        do_reset();
        hold(G, 6);
        hold(Y, 2);
        check_cnt++; if (a_phase !== 2'd2) $display("FAIL short_yellow: got %0d want 2", a_phase); else pass_cnt++;
        step(R);
        check_cnt++; if (a_fault !== 1'b0) $display("FAIL short_early: got %0d want 0", a_fault); else pass_cnt++;
        step(R);
        check_cnt++; if (a_fault !== 1'b1) $display("FAIL short_fault: got %0d want 1", a_fault); else pass_cnt++;
        check_cnt++; if (a_code !== 3'd3) $display("FAIL short_code: got %0d want 3", a_code); else pass_cnt++;
        check_cnt++; if (a_phase !== 2'd0) $display("FAIL short_phase: got %0d want 0", a_phase); else pass_cnt++;
        check_cnt++; if (a_cycle !== 8'd0) $display("FAIL short_cycle: got %0d want 0", a_cycle); else pass_cnt++;
        hold(R, 3);
        check_cnt++; if (a_code !== 3'd3 || a_fault !== 1'b1) $display("FAIL short_held: got code %0d fault %0d want 3 1", a_code, a_fault); else pass_cnt++;
    endtask

    task automatic test_min_boundary();
        do_reset();
        hold(G, 6);
        hold(Y, 5);
        hold(R, 2);
        check_cnt++; if (a_phase !== 2'd3 || a_fault !== 1'b0) $display("FAIL min_exact: got phase %0d fault %0d want 3 0", a_phase, a_fault); else pass_cnt++;
        check_cnt++; if (a_last !== 8'd4) $display("FAIL min_last: got %0d want 4", a_last); else pass_cnt++;
    endtask

    task automatic test_illegal_transition();
        do_reset();
        hold(G, 6);
        hold(R, 2);
        check_cnt++; if (a_fault !== 1'b1) $display("FAIL trans_fault: got %0d want 1", a_fault); else pass_cnt++;
        check_cnt++; if (a_code !== 3'd2) $display("FAIL trans_code: got %0d want 2", a_code); else pass_cnt++;
        hold(3'b110, 3);
        check_cnt++; if (a_code !== 3'd2) $display("FAIL trans_first_held: got %0d want 2", a_code); else pass_cnt++;
    endtask

    task automatic test_illegal_code_clear();
        do_reset();
        hold(G, 6);
        hold(Y, 6);
        hold(R, 6);
        check_cnt++; if (a_phase !== 2'd3) $display("FAIL code_red: got %0d want 3", a_phase); else pass_cnt++;
        clr = 1'b1;
        step(R);
        clr = 1'b0;
        check_cnt++; if (a_phase !== 2'd3 || a_fault !== 1'b0) $display("FAIL clr_ignored: got phase %0d fault %0d want 3 0", a_phase, a_fault); else pass_cnt++;
        hold(3'b011, 2);
        check_cnt++; if (a_fault !== 1'b1) $display("FAIL code_fault: got %0d want 1", a_fault); else pass_cnt++;
        check_cnt++; if (a_code !== 3'd1) $display("FAIL code_code: got %0d want 1", a_code); else pass_cnt++;
        clr = 1'b1;
        step(R);
        clr = 1'b0;
        check_cnt++; if (a_fault !== 1'b0) $display("FAIL clr_fault: got %0d want 0", a_fault); else pass_cnt++;
        check_cnt++; if (a_code !== 3'd0) $display("FAIL clr_code: got %0d want 0", a_code); else pass_cnt++;
        check_cnt++; if (a_phase !== 2'd0) $display("FAIL clr_phase: got %0d want 0", a_phase); else pass_cnt++;
        check_cnt++; if (a_last !== 8'd5) $display("FAIL clr_last_kept: got %0d want 5", a_last); else pass_cnt++;
        step(R);
        check_cnt++; if (a_phase !== 2'd3 || a_fault !== 1'b0) $display("FAIL clr_reenter: got phase %0d fault %0d want 3 0", a_phase, a_fault); else pass_cnt++;
    endtask

    task automatic test_stuck();
        int  n;
        bit  seen;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(G);
            if (b_phase == 2'd1) seen = 1'b1;
        end
        check_cnt++; if (!seen) $display("FAIL stuck_entry: got phase %0d want 1 within 10 clocks", b_phase); else pass_cnt++;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(G);
            n++;
            if (b_code == 3'd4) seen = 1'b1;
        end
        check_cnt++; if (!seen || n < 77 || n > 83) $display("FAIL stuck_timing: got %0d clocks (seen %0d) want 77..83", n, seen); else pass_cnt++;
        check_cnt++; if (b_fault !== 1'b1 || b_phase !== 2'd0) $display("FAIL stuck_flags: got fault %0d phase %0d want 1 0", b_fault, b_phase); else pass_cnt++;
    endtask

    task automatic test_wrap_reset();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            hold(G, 5);
            hold(Y, 5);
            hold(R, 5);
        end
        check_cnt++; if (a_cycle !== 8'd255) $display("FAIL wrap_255: got %0d want 255", a_cycle); else pass_cnt++;
        check_cnt++; if (a_fault !== 1'b0) $display("FAIL wrap_nofault: got %0d want 0", a_fault); else pass_cnt++;
        hold(G, 2);
        check_cnt++; if (a_cycle !== 8'd0) $display("FAIL wrap_0: got %0d want 0", a_cycle); else pass_cnt++;
        hold(G, 3);
        hold(Y, 3);
        check_cnt++; if (a_phase !== 2'd2 || a_last !== 8'd4) $display("FAIL mid_yellow: got phase %0d last %0d want 2 4", a_phase, a_last); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        check_cnt++; if (a_phase !== 2'd0) $display("FAIL async_phase: got %0d want 0", a_phase); else pass_cnt++;
        check_cnt++; if (a_fault !== 1'b0 || a_code !== 3'd0) $display("FAIL async_fault: got fault %0d code %0d want 0 0", a_fault, a_code); else pass_cnt++;
        check_cnt++; if (a_last !== 8'd0) $display("FAIL async_last: got %0d want 0", a_last); else pass_cnt++;
        check_cnt++; if (a_cycle !== 8'd0) $display("FAIL async_cycle: got %0d want 0", a_cycle); else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Test sequence and summary.
    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        rst_n     = 1'b0;
        lights    = 3'b000;
        clr       = 1'b0;
        test_reset();
        test_legal_sequence();
        test_short_dwell();
        test_min_boundary();
        test_illegal_transition();
        test_illegal_code_clear();
        test_stuck();
        test_wrap_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
